mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Parametrised memory + writeback stage with a registered MEM/WB pipeline boundary.
- Performs sized loads and stores (byte, half, word) with byte-lane enables and sign/zero extension.
- Detects misaligned accesses.
- Selects the writeback value: link address, load data or ALU result.
- Sits between execute and the register file and exposes a valid/ready handshake on both sides, so downstream stalls propagate back to execute.

Parameters:
DATA_W, 32, datapath width; a multiple of 8, either 32 or 64.
ADDR_W, 8, word-address width of data memory; DEPTH = 2**ADDR_W words.
RD_W, 5, destination-register index width.
LANES, DATA_W/8 (derived, localparam), byte lanes per word; OFS_W = log2(LANES).

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  kill the op in the W register and any op accepted this cycle
in_valid  in  1  upstream op present
in_ready  out  1  stage accepts op this cycle
in_alu_res  in  DATA_W  ALU result / effective byte address
in_store_data  in  DATA_W  store data, right-aligned
in_link  in  DATA_W  return address for jumps
in_rd  in  RD_W  destination register
in_is_jump  in  1  writeback = in_link
in_reg_wren  in  1  op writes the register file
in_mem_wren  in  1  store
in_mem_to_reg  in  1  load
in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W = 64 only)
in_unsigned  in  1  zero-extend loads
out_valid  out  1  W register holds a live op
out_ready  in  1  consumer takes the op
out_write_data  out  DATA_W  writeback value
out_rd  out  RD_W  destination register
out_reg_wren  out  1  register write enable, already qualified
out_misaligned  out  1  op faulted on alignment

Behaviour:
- Reset (async, rst = 1): out_valid, out_write_data, out_rd, out_reg_wren and out_misaligned all clear to 0. Memory contents are not reset.
- Ready rule: in_ready = !out_valid || out_ready. Accept = in_valid && in_ready.
- Latency: an op accepted at edge N appears on the outputs after edge N (1 cycle). Throughput is 1 op/clk while out_ready = 1.
- Stall hold: while out_valid && !out_ready, all outputs hold. The RAM read-address register loads only on accept, so the load data stays stable while held.
- Address map:
  - Byte offset = in_alu_res[OFS_W-1:0].
  - Word index = in_alu_res[OFS_W+ADDR_W-1:OFS_W].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Alignment: an access is misaligned when the offset is not a multiple of the access size in bytes. Size 3 with DATA_W = 32 is treated as misaligned.
- Stores:
  - Commit at the accepting edge.
  - Byte-lane enables are the size mask shifted left by the offset; store data is replicated or shifted into those lanes.
  - A misaligned store writes nothing.
- Loads:
  - Read lanes are shifted right by the offset, then sign- or zero-extended to DATA_W per in_unsigned.
  - Word load on DATA_W = 32: no extension.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data. One op per cycle, so there is no same-cycle conflict.
- Writeback mux priority: in_is_jump → in_link; else in_mem_to_reg → load data; else in_alu_res.
- out_reg_wren = in_reg_wren && !misaligned && (rd != 0), registered.
- out_misaligned is registered from any load or store with an alignment fault. Non-memory ops never fault.
- Flush:
  - out_valid = 0 after the edge.
  - An op accepted in the same cycle is dropped and its store is suppressed.
  - Flush beats accept; flush during a stall drops the held op.
- Reset mid-stall: the held op is lost and out_valid = 0 immediately (asynchronous).

Decomposition:
- Package mem_wb_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - function for the lane mask from size and offset;
  - function for load extract/extend;
  - function for the misalignment check.
- Sub-module dmem_bram: single-port synchronous RAM, DEPTH × DATA_W, per-byte write enables, registered read address, read-after-write returning new data.

Test Plan:
1. Reset asserted mid-stream with out_valid = 1 → all outputs 0 immediately; after release, first accepted op appears 1 cycle later.
2. Store word 0xDEADBEEF at addr 0x10, then LB at 0x13 signed, then LBU at 0x13 → out_write_data = 0xFFFFFFDE, then 0x000000DE.
3. SH 0x1234 at 0x22, then LW at 0x20 (word previously 0) → out_write_data = 0x12340000; SH at 0x21 → out_misaligned = 1, out_reg_wren = 0, memory unchanged.
4. out_ready held 0 for 3 cycles with a load in W → in_ready = 0, outputs constant; release → next op retires with no duplicate and no loss.
5. Jump with in_link = 0x44, in_rd = 31, in_mem_to_reg = 1 → out_write_data = 0x44 (jump wins); any op with rd = 0 → out_reg_wren = 0.
6. flush coincident with a store at 0x30 of 0xA5A5A5A5 → out_valid = 0 next cycle; a following LW at 0x30 returns the prior value. Address 0x430 (wraps) aliases to 0x30.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared encodings and helpers for the memory/writeback stage.
// Helpers work on the widest supported datapath; callers truncate.
package mem_wb_pkg;

    localparam int unsigned MAX_W     = 64;
    localparam int unsigned MAX_LANES = MAX_W / 8;
    localparam int unsigned MAX_OFS_W = 3;

    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE  = 2'd0;
    localparam size_t SZ_HALF  = 2'd1;
    localparam size_t SZ_WORD  = 2'd2;
    localparam size_t SZ_DWORD = 2'd3;

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [MAX_LANES-1:0] lane_mask(
        input size_t                size,
        input logic [MAX_OFS_W-1:0] ofs
    );
        logic [MAX_LANES-1:0] base;
        base = '0;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << ofs;
    endfunction

    // Offset must be a multiple of the access size; dword needs a 64-bit datapath.
    function automatic logic is_misaligned(
        input size_t                size,
        input logic [MAX_OFS_W-1:0] ofs,
        input int unsigned          data_w
    );
        logic r;
        r = 1'b0;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = ofs[0];
            SZ_WORD: r = |ofs[1:0];
            default: r = (data_w != MAX_W) || (|ofs);
        endcase
        return r;
    endfunction

    // Right-align the addressed lanes, then sign- or zero-extend.
    function automatic logic [MAX_W-1:0] load_extract(
        input logic [MAX_W-1:0]     word,
        input size_t                size,
        input logic [MAX_OFS_W-1:0] ofs,
        input logic                 uns
    );
        logic [MAX_W-1:0] sh;
        logic [MAX_W-1:0] r;
        sh = word >> {ofs, 3'b000};
        r  = sh;
        case (size)
            SZ_BYTE: r = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_HALF: r = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_WORD: r = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_wb_stage_dmem.sv
// Single-port data RAM: per-byte write enables, registered read address.
// Reads see the array through the held address, so a write is visible next cycle.
module dmem_bram
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Address only moves on accept so held load data stays stable during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (en) begin
            addr_q <= addr;
        end
    end

    assign rdata = mem[addr_q];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access + writeback select with a registered MEM/WB boundary
// and valid/ready handshake on both sides.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [DATA_W-1:0] in_link,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_is_jump,
    input  logic              in_reg_wren,
    input  logic              in_mem_wren,
    input  logic              in_mem_to_reg,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_write_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_wren,
    output logic              out_misaligned
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(LANES);

    logic [OFS_W-1:0]  ofs;
    logic [ADDR_W-1:0] widx;
    logic              accept;
    logic              take;
    logic              is_mem;
    logic              mis;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    logic [DATA_W-1:0] wb_q;
    logic              ld_q;
    size_t             size_q;
    logic [OFS_W-1:0]  ofs_q;
    logic              uns_q;

    assign ofs  = in_alu_res[OFS_W-1:0];
    assign widx = in_alu_res[OFS_W+ADDR_W-1:OFS_W];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Flush kills an op in the same cycle it would be accepted.
    assign take     = accept && !flush;

    assign is_mem = in_mem_wren || in_mem_to_reg;
    assign mis    = is_mem && is_misaligned(in_size, MAX_OFS_W'(ofs), DATA_W);

    assign be    = (take && in_mem_wren && !mis)
                 ? LANES'(lane_mask(in_size, MAX_OFS_W'(ofs))) : '0;
    assign wdata = in_store_data << {ofs, 3'b000};

    dmem_bram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .en    (take),
        .we    (be),
        .addr  (widx),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_rd         <= '0;
            out_reg_wren   <= 1'b0;
            out_misaligned <= 1'b0;
            wb_q           <= '0;
            ld_q           <= 1'b0;
            size_q         <= SZ_BYTE;
            ofs_q          <= '0;
            uns_q          <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (take) begin
                out_rd         <= in_rd;
                out_reg_wren   <= in_reg_wren && !mis && (in_rd != '0);
                out_misaligned <= mis;
                wb_q           <= in_is_jump ? in_link : in_alu_res;
                ld_q           <= !in_is_jump && in_mem_to_reg;
                size_q         <= in_size;
                ofs_q          <= ofs;
                uns_q          <= in_unsigned;
            end
        end
    end

    // Load data comes from the RAM behind its registered address.
    assign out_write_data = ld_q
        ? DATA_W'(load_extract(MAX_W'(rdata), size_q, MAX_OFS_W'(ofs_q), uns_q))
        : wb_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (DATA_W = 32, ADDR_W = 8).
module tb_mem_wb_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RD_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu_res;
    logic [DATA_W-1:0] in_store_data;
    logic [DATA_W-1:0] in_link;
    logic [RD_W-1:0]   in_rd;
    logic              in_is_jump;
    logic              in_reg_wren;
    logic              in_mem_wren;
    logic              in_mem_to_reg;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_write_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_wren;
    logic              out_misaligned;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_W   (RD_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_res     (in_alu_res),
        .in_store_data  (in_store_data),
        .in_link        (in_link),
        .in_rd          (in_rd),
        .in_is_jump     (in_is_jump),
        .in_reg_wren    (in_reg_wren),
        .in_mem_wren    (in_mem_wren),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_write_data (out_write_data),
        .out_rd         (out_rd),
        .out_reg_wren   (out_reg_wren),
        .out_misaligned (out_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] link,
                         input logic [4:0] rd, input logic jump, input logic regw, input logic memw,
                         input logic m2r, input logic [1:0] size, input logic uns);
        in_valid      = 1'b1;
        in_alu_res    = alu;
        in_store_data = sd;
        in_link       = link;
        in_rd         = rd;
        in_is_jump    = jump;
        in_reg_wren   = regw;
        in_mem_wren   = memw;
        in_mem_to_reg = m2r;
        in_size       = size;
        in_unsigned   = uns;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        in_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        drive(val, 32'h0, 32'h0, rd, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        drive(addr, data, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, size, 1'b0);
    endtask

    task automatic ld(input logic [31:0] addr, input logic [4:0] rd, input logic [1:0] size,
                      input logic uns);
        drive(addr, 32'h0, 32'h0, rd, 1'b0, 1'b1, 1'b0, 1'b1, size, uns);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();
        #1;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", 64'(out_write_data), 64'h0);
        check("rst_rd", 64'(out_rd), 64'h0);
        check("rst_wren", 64'(out_reg_wren), 64'h0);
        check("rst_mis", 64'(out_misaligned), 64'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset asserted while an op is held in a stall
        alu_op(5'd3, 32'h55);
        tick();
        check("pre_rst_valid", 64'(out_valid), 64'h1);
        check("pre_rst_data", 64'(out_write_data), 64'h55);
        out_ready = 1'b0;
        idle();
        tick();
        check("stall_pre_rst_valid", 64'(out_valid), 64'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_data", 64'(out_write_data), 64'h0);
        check("async_rst_rd", 64'(out_rd), 64'h0);
        check("async_rst_wren", 64'(out_reg_wren), 64'h0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        alu_op(5'd4, 32'h77);
        #1;
        check("post_rst_not_yet", 64'(out_valid), 64'h0);
        tick();
        check("post_rst_valid", 64'(out_valid), 64'h1);
        check("post_rst_data", 64'(out_write_data), 64'h77);
        check("post_rst_rd", 64'(out_rd), 64'h4);

        // Word store, then signed / unsigned sub-word loads (back to back)
        st(32'h10, 32'hDEADBEEF, 2'd2);
        tick();
        check("sw_mis", 64'(out_misaligned), 64'h0);
        check("sw_wren", 64'(out_reg_wren), 64'h0);
        ld(32'h13, 5'd5, 2'd0, 1'b0);
        tick();
        check("lb_signed", 64'(out_write_data), 64'hFFFFFFDE);
        check("lb_wren", 64'(out_reg_wren), 64'h1);
        ld(32'h13, 5'd5, 2'd0, 1'b1);
        tick();
        check("lbu", 64'(out_write_data), 64'h000000DE);
        ld(32'h12, 5'd6, 2'd1, 1'b0);
        tick();
        check("lh_signed", 64'(out_write_data), 64'hFFFFDEAD);
        ld(32'h10, 5'd6, 2'd1, 1'b1);
        tick();
        check("lhu", 64'(out_write_data), 64'h0000BEEF);

        // Half store into upper lanes, misaligned half store
        st(32'h20, 32'h0, 2'd2);
        tick();
        st(32'h22, 32'h1234, 2'd1);
        tick();
        ld(32'h20, 5'd7, 2'd2, 1'b0);
        tick();
        check("sh_then_lw", 64'(out_write_data), 64'h12340000);
        drive(32'h21, 32'hFFFF, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tick();
        check("sh_mis_flag", 64'(out_misaligned), 64'h1);
        check("sh_mis_wren", 64'(out_reg_wren), 64'h0);
        ld(32'h20, 5'd7, 2'd2, 1'b0);
        tick();
        check("mem_unchanged", 64'(out_write_data), 64'h12340000);
        check("lw_mis_clear", 64'(out_misaligned), 64'h0);
        ld(32'h22, 5'd7, 2'd2, 1'b0);
        tick();
        check("lw_mis_flag", 64'(out_misaligned), 64'h1);
        check("lw_mis_wren", 64'(out_reg_wren), 64'h0);
        ld(32'h20, 5'd7, 2'd3, 1'b0);
        tick();
        check("dword_on_32_mis", 64'(out_misaligned), 64'h1);

        // Downstream stall with a load held in W
        ld(32'h10, 5'd7, 2'd2, 1'b0);
        tick();
        check("hold_load", 64'(out_write_data), 64'hDEADBEEF);
        out_ready = 1'b0;
        alu_op(5'd8, 32'h99);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 64'(out_valid), 64'h1);
            check("stall_data", 64'(out_write_data), 64'hDEADBEEF);
            check("stall_rd", 64'(out_rd), 64'h7);
            check("stall_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 64'(in_ready), 64'h1);
        tick();
        check("after_stall_data", 64'(out_write_data), 64'h99);
        check("after_stall_rd", 64'(out_rd), 64'h8);
        idle();
        tick();
        check("no_duplicate", 64'(out_valid), 64'h0);

        // Jump priority and rd = 0 suppression
        drive(32'h10, 32'h0, 32'h44, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        check("jump_data", 64'(out_write_data), 64'h44);
        check("jump_wren", 64'(out_reg_wren), 64'h1);
        check("jump_rd", 64'(out_rd), 64'd31);
        alu_op(5'd0, 32'h5A);
        tick();
        check("rd0_wren", 64'(out_reg_wren), 64'h0);
        check("rd0_valid", 64'(out_valid), 64'h1);

        // Flush kills a coincident store; address aliasing
        st(32'h30, 32'h11111111, 2'd2);
        tick();
        flush = 1'b1;
        st(32'h30, 32'hA5A5A5A5, 2'd2);
        tick();
        check("flush_valid", 64'(out_valid), 64'h0);
        flush = 1'b0;
        ld(32'h430, 5'd9, 2'd2, 1'b0);
        tick();
        check("flush_no_store", 64'(out_write_data), 64'h11111111);
        check("alias_valid", 64'(out_valid), 64'h1);
        st(32'h430, 32'h0BADCAFE, 2'd2);
        tick();
        ld(32'h30, 5'd10, 2'd2, 1'b0);
        tick();
        check("alias_store", 64'(out_write_data), 64'h0BADCAFE);

        // Flush during a stall drops the held op
        alu_op(5'd11, 32'h123);
        tick();
        out_ready = 1'b0;
        idle();
        tick();
        check("held_before_flush", 64'(out_valid), 64'h1);
        flush = 1'b1;
        tick();
        check("flush_in_stall", 64'(out_valid), 64'h0);
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
